// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bus: control inputs, instruction-ROM port and IF/ID outputs
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic [1:0]        stall;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;

  modport master (
    input  stall, branch_flag, branch_target, flush, new_pc, rom_inst,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    output stall, branch_flag, branch_target, flush, new_pc, rom_inst,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: PC register, ROM fetch, IF/ID register with stall, delayed branch and flush
module inst_fetch #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  if_bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic              rom_ce_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              hold_pc;

  // stall=2'b10 is not a legal control encoding; treat it as a full hold
  assign hold_pc = if_bus.stall[0] | if_bus.stall[1];

  always_comb begin
    pc_d = pc_q;
    if (!rom_ce_q) begin
      pc_d = RESET_PC;
    end else if (if_bus.flush) begin
      pc_d = if_bus.new_pc & ALIGN_MASK;
    end else if (hold_pc) begin
      pc_d = pc_q;
    end else if (if_bus.branch_flag) begin
      pc_d = if_bus.branch_target & ALIGN_MASK;
    end else begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (if_bus.flush) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (if_bus.stall[1]) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end else if (if_bus.stall[0]) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else begin
      // zero-latency ROM: the word for pc_q is captured at the edge that advances pc
      id_pc_d    = pc_q;
      id_inst_d  = if_bus.rom_inst;
      id_valid_d = rom_ce_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce_q   <= 1'b0;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      rom_ce_q   <= 1'b1;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign if_bus.rom_ce   = rom_ce_q;
  assign if_bus.rom_addr = pc_q;
  assign if_bus.id_pc    = id_pc_q;
  assign if_bus.id_inst  = id_inst_q;
  assign if_bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed table plus random stimulus against a reference model for inst_fetch
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  stall;
    logic        bf;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] np;
    logic [31:0] e_pc;
    logic [31:0] e_idpc;
    logic        e_valid;
    logic        e_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] s, input logic bf, input logic [31:0] bt,
                     input logic fl, input logic [31:0] np,
                     input logic [31:0] e_pc, input logic [31:0] e_idpc,
                     input logic e_valid, input logic e_zero);
    vec_t v;
    v.stall = s; v.bf = bf; v.bt = bt; v.fl = fl; v.np = np;
    v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_valid = e_valid; v.e_zero = e_zero;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] s, input logic bf, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np);
    bus.stall = s; bus.branch_flag = bf; bus.branch_target = bt;
    bus.flush = fl; bus.new_pc = np;
  endtask

  // reference model state
  logic        m_ce;
  logic [31:0] m_pc, m_idpc, m_inst;
  logic        m_valid;

  task automatic model_reset();
    m_ce = 1'b0; m_pc = 32'h0; m_idpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic bf, input logic [31:0] bt,
                            input logic fl, input logic [31:0] np);
    logic [31:0] npc;
    if (!m_ce)                 npc = 32'h0;
    else if (fl)               npc = np - (np % 4);
    else if (s != 2'b00)       npc = m_pc;
    else if (bf)               npc = bt - (bt % 4);
    else                       npc = m_pc + 4;
    if (fl) begin
      m_idpc = 0; m_inst = 0; m_valid = 0;
    end else if (s[1]) begin
      // hold
    end else if (s[0]) begin
      m_idpc = 0; m_inst = 0; m_valid = 0;
    end else begin
      m_idpc = m_pc; m_inst = rom_word(m_pc); m_valid = m_ce;
    end
    m_pc = npc;
    m_ce = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rom_ce"},   32'(bus.rom_ce),   32'(m_ce));
    chk({tag, ".rom_addr"}, bus.rom_addr,      m_pc);
    chk({tag, ".id_pc"},    bus.id_pc,         m_idpc);
    chk({tag, ".id_inst"},  bus.id_inst,       m_inst);
    chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(m_valid));
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);

    //         stall  bf    bt            fl    np            pc            id_pc         v     zero
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h0,        32'h0,        1'b0, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h4,        32'h0,        1'b1, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h8,        32'h4,        1'b1, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'hC,        32'h8,        1'b1, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h10,       32'hC,        1'b1, 1'b0);
    add(2'b00, 1'b1, 32'h40,       1'b0, 32'h0,       32'h40,       32'h10,       1'b1, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h44,       32'h40,       1'b1, 1'b0);
    add(2'b00, 1'b1, 32'h43,       1'b0, 32'h0,       32'h40,       32'h44,       1'b1, 1'b0);
    add(2'b00, 1'b1, 32'h20,       1'b0, 32'h0,       32'h20,       32'h40,       1'b1, 1'b0);
    add(2'b11, 1'b0, 32'h0,        1'b0, 32'h0,       32'h20,       32'h40,       1'b1, 1'b0);
    add(2'b11, 1'b0, 32'h0,        1'b0, 32'h0,       32'h20,       32'h40,       1'b1, 1'b0);
    add(2'b11, 1'b0, 32'h0,        1'b0, 32'h0,       32'h20,       32'h40,       1'b1, 1'b0);
    add(2'b01, 1'b0, 32'h0,        1'b0, 32'h0,       32'h20,       32'h0,        1'b0, 1'b1);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h24,       32'h20,       1'b1, 1'b0);
    add(2'b10, 1'b0, 32'h0,        1'b0, 32'h0,       32'h24,       32'h20,       1'b1, 1'b0);
    add(2'b01, 1'b1, 32'h100,      1'b0, 32'h0,       32'h24,       32'h0,        1'b0, 1'b1);
    add(2'b00, 1'b1, 32'h100,      1'b0, 32'h0,       32'h100,      32'h24,       1'b1, 1'b0);
    add(2'b11, 1'b1, 32'h40,       1'b1, 32'h180,     32'h180,      32'h0,        1'b0, 1'b1);
    add(2'b00, 1'b0, 32'h0,        1'b1, 32'h1FF,     32'h1FC,      32'h0,        1'b0, 1'b1);
    add(2'b00, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,      32'hFFFF_FFFC, 32'h1FC,     1'b1, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0);
    add(2'b00, 1'b0, 32'h0,        1'b0, 32'h0,       32'h4,        32'h0,        1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("reset.rom_ce",   32'(bus.rom_ce),   32'h0);
    chk("reset.rom_addr", bus.rom_addr,      32'h0);
    chk("reset.id_pc",    bus.id_pc,         32'h0);
    chk("reset.id_inst",  bus.id_inst,       32'h0);
    chk("reset.id_valid", 32'(bus.id_valid), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].bf, vecs[i].bt, vecs[i].fl, vecs[i].np);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.rom_ce", i),   32'(bus.rom_ce),   32'h1);
      chk($sformatf("vec%0d.rom_addr", i), bus.rom_addr,      vecs[i].e_pc);
      chk($sformatf("vec%0d.id_pc", i),    bus.id_pc,         vecs[i].e_idpc);
      chk($sformatf("vec%0d.id_valid", i), 32'(bus.id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.id_inst", i),  bus.id_inst,
          vecs[i].e_zero ? 32'h0 : rom_word(vecs[i].e_idpc));
    end

    // asynchronous reset in the middle of a running stream
    drive(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("areset.rom_ce",   32'(bus.rom_ce),   32'h0);
    chk("areset.rom_addr", bus.rom_addr,      32'h0);
    chk("areset.id_pc",    bus.id_pc,         32'h0);
    chk("areset.id_inst",  bus.id_inst,       32'h0);
    chk("areset.id_valid", 32'(bus.id_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int c = 0; c < 400; c++) begin
      logic [1:0]  s;
      logic        bf, fl;
      logic [31:0] bt, np;
      s  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bf = ($urandom_range(0, 4) == 0);
      bt = $urandom;
      fl = ($urandom_range(0, 15) == 0);
      np = $urandom;
      if (c == 0) begin
        s = 2'b00; bf = 1'b1; fl = 1'b1;
      end
      if (c == 200) begin
        bf = 1'b1; bt = 32'hFFFF_FFF8; s = 2'b00; fl = 1'b0;
      end
      drive(s, bf, bt, fl, np);
      model_step(s, bf, bt, fl, np);
      @(posedge clk);
      @(negedge clk);
      chk_model($sformatf("rnd%0d", c));
      if (bus.id_valid && !bus.rom_ce) begin
        n_err++;
        $display("FAIL rnd%0d.valid_without_ce: id_valid=1 rom_ce=0", c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
